// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding muxes and hazard stall (option macro: ID_EX_FORWARDING_EN)
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              id_uses_rt,
   input  logic [3:0]        id_alu_control,
   input  logic              id_alu_src,
   input  logic              id_reg_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              flush,
   input  logic              exmem_reg_write,
   input  logic [REG_W-1:0]  exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_reg_write,
   input  logic [REG_W-1:0]  memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_A,
   output logic [DATA_W-1:0] ex_B,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [3:0]        ex_alu_control,
   output logic [REG_W-1:0]  ex_dest,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg
);

   // A bubble still carries ADD so the ALU sees a harmless opcode.
   localparam logic [3:0] ALU_ADD = 4'b0010;

   logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
   logic [REG_W-1:0]  rs_q, rt_q;
   logic              alu_src_q;
   logic [DATA_W-1:0] rs_fwd, rt_fwd;
   logic              bubble;

   assign bubble = flush || stall || !id_valid;

   // Stage registers: reset clears, a bubble kills the slot, otherwise capture ID.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid       <= 1'b0;
         rs_data_q      <= '0;
         rt_data_q      <= '0;
         imm_q          <= '0;
         rs_q           <= '0;
         rt_q           <= '0;
         ex_dest        <= '0;
         ex_alu_control <= '0;
         alu_src_q      <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_mem_read    <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_mem_to_reg  <= 1'b0;
      end else if (bubble) begin
         ex_valid       <= 1'b0;
         rs_data_q      <= '0;
         rt_data_q      <= '0;
         imm_q          <= '0;
         rs_q           <= '0;
         rt_q           <= '0;
         ex_dest        <= '0;
         ex_alu_control <= ALU_ADD;
         alu_src_q      <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_mem_read    <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_mem_to_reg  <= 1'b0;
      end else begin
         ex_valid       <= 1'b1;
         rs_data_q      <= id_rs_data;
         rt_data_q      <= id_rt_data;
         imm_q          <= id_imm;
         rs_q           <= id_rs;
         rt_q           <= id_rt;
         ex_dest        <= id_reg_dst ? id_rd : id_rt;
         ex_alu_control <= id_alu_control;
         alu_src_q      <= id_alu_src;
         ex_reg_write   <= id_reg_write;
         ex_mem_read    <= id_mem_read;
         ex_mem_write   <= id_mem_write;
         ex_mem_to_reg  <= id_mem_to_reg;
      end
   end

`ifdef ID_EX_FORWARDING_EN
   // Operand forwarding: the younger EX/MEM result beats MEM/WB; r0 is never forwarded.
   always_comb begin
      rs_fwd = rs_data_q;
      rt_fwd = rt_data_q;
      if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q)
         rs_fwd = exmem_result;
      else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q)
         rs_fwd = memwb_result;
      if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q)
         rt_fwd = exmem_result;
      else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q)
         rt_fwd = memwb_result;
   end

   // Only a load in EX cannot be forwarded in time; hold ID for one bubble. Flush wins.
   always_comb begin
      stall = 1'b0;
      if (id_valid && !flush && ex_valid && ex_mem_read && ex_dest != '0 &&
          (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt)))
         stall = 1'b1;
   end
`else
   function automatic logic raw_hit(input logic we, input logic [REG_W-1:0] dst,
                                    input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                    input logic uses_rt);
      return we && dst != '0 && (dst == rs || (uses_rt && dst == rt));
   endfunction

   // Forwarding results are not consumed in this build.
   logic unused_results;
   assign unused_results = ^{exmem_result, memwb_result};

   // No bypass: operands come straight from the stage registers.
   always_comb begin
      rs_fwd = rs_data_q;
      rt_fwd = rt_data_q;
   end

   // Hold ID until every in-flight writer of its sources has reached the register file.
   always_comb begin
      stall = 1'b0;
      if (id_valid && !flush &&
          (raw_hit(ex_reg_write, ex_dest, id_rs, id_rt, id_uses_rt) ||
           raw_hit(exmem_reg_write, exmem_rd, id_rs, id_rt, id_uses_rt) ||
           raw_hit(memwb_reg_write, memwb_rd, id_rs, id_rt, id_uses_rt)))
         stall = 1'b1;
   end
`endif

   assign ex_A          = rs_fwd;
   assign ex_store_data = rt_fwd;
   assign ex_B          = alu_src_q ? imm_q : rt_fwd;

endmodule
